// File: rtl/dmem_pkg.sv
// Shared types and encodings for the memory-stage access sequencer.
// Store-lane helpers live here so the top stays focused on sequencing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY  = 2'b01,
    DONE  = 2'b10,
    FAULT = 2'b11
  } state_t;

  typedef logic [3:0] wmask_t;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SW   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SB   = 2'b11;

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LTH = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LB  = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LBU = 3'b110;

  function automatic wmask_t store_mask(input logic [1:0] mw, input logic [1:0] ofs);
    wmask_t m;
    case (mw)
      MW_SW:   m = 4'b1111;
      MW_SH:   m = ofs[1] ? 4'b1100 : 4'b0011;
      MW_SB:   m = wmask_t'(4'b0001 << ofs);
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] mw, input logic [31:0] wd);
    logic [31:0] d;
    case (mw)
      MW_SH:   d = {2{wd[15:0]}};
      MW_SB:   d = {4{wd[7:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // A store decides alignment on its own; a load only matters when no store is present.
  // LTH extracts a halfword, so it needs only halfword alignment.
  function automatic logic is_misaligned(input logic [1:0] mw, input logic [2:0] lc,
                                         input logic [1:0] ofs);
    logic mis;
    if (mw != MW_NONE) begin
      case (mw)
        MW_SW:   mis = (ofs != 2'b00);
        MW_SH:   mis = ofs[0];
        default: mis = 1'b0;
      endcase
    end else begin
      case (lc)
        LD_LH, LD_LHU, LD_LTH: mis = ofs[0];
        LD_LB, LD_LBU:         mis = 1'b0;
        default:               mis = (ofs != 2'b00);
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_load_extract.sv
// Combinational load-result formatter: selects the addressed half/byte
// of a read word and extends it according to the load code.
module load_extract
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load_code,
  input  logic [1:0]  addr_lo,
  output logic [31:0] result
);

  function automatic logic [31:0] sext16(input logic signed [15:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  function automatic logic [31:0] sext8(input logic signed [7:0] v);
    logic signed [31:0] r;
    r = v;
    return r;
  endfunction

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase

    case (load_code)
      LD_LH:   result = sext16(half_sel);
      LD_LHU:  result = {16'h0000, half_sel};
      LD_LB:   result = sext8(byte_sel);
      LD_LBU:  result = {24'h000000, byte_sel};
      LD_LTH:  result = {half_sel, 16'h0000};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage sequencer: turns decoded load/store controls into a single
// req/ready access, stalls the pipeline until it completes, faults or times out.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic [1:0]        MemWrite,
  input  logic [2:0]        load_code,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misaligned_err,
  output logic              bus_err
);

  state_t      state, state_nxt;
  logic [7:0]  tmo_cnt;
  logic        tmo_last;
  logic        is_load;
  logic        fault_bus;
  logic [2:0]  lc_q;
  logic [1:0]  ofs_q;
  logic        is_write;
  logic        active;
  logic        mis;
  logic [31:0] extracted;

  assign is_write = (MemWrite != MW_NONE);
  assign active   = MemRead | is_write;
  assign mis      = is_misaligned(MemWrite, load_code, addr[1:0]);
  assign tmo_last = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

  load_extract u_extract (
    .rdata     (mem_rdata),
    .load_code (lc_q),
    .addr_lo   (ofs_q),
    .result    (extracted)
  );

  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    mem_req        = 1'b0;
    load_valid     = 1'b0;
    misaligned_err = 1'b0;
    bus_err        = 1'b0;
    case (state)
      IDLE: begin
        if (active) begin
          stall     = 1'b1;
          state_nxt = mis ? FAULT : BUSY;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready)     state_nxt = DONE;
        else if (tmo_last) state_nxt = FAULT;
      end
      DONE: begin
        load_valid = is_load;
        state_nxt  = IDLE;
      end
      default: begin
        misaligned_err = ~fault_bus;
        bus_err        = fault_bus;
        state_nxt      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= 32'h0;
      mem_wmask <= 4'h0;
      load_data <= 32'h0;
      is_load   <= 1'b0;
      fault_bus <= 1'b0;
      lc_q      <= 3'b000;
      ofs_q     <= 2'b00;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (active) begin
            fault_bus <= 1'b0;
            if (!mis) begin
              mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
              mem_we    <= is_write;
              mem_wmask <= store_mask(MemWrite, addr[1:0]);
              mem_wdata <= store_data(MemWrite, wdata);
              is_load   <= ~is_write;
              lc_q      <= load_code;
              ofs_q     <= addr[1:0];
              tmo_cnt   <= 8'd0;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (is_load) load_data <= extracted;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            if (tmo_last) fault_bus <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a transaction-level model predicts every
// cycle's handshake/pulse outputs, plus literal checks on key results.
module tb_dmem_access_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [2:0]  load_code;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned_err;
  logic        bus_err;

  dmem_access_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .load_code      (load_code),
    .addr           (addr),
    .wdata          (wdata),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .stall          (stall),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .misaligned_err (misaligned_err),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int stall_total = 0, req_total = 0, lv_total = 0, mis_total = 0, bus_total = 0;
  logic chk_en = 1'b0;

  logic        exp_stall, exp_req, exp_lv, exp_mis, exp_bus, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Access size in bytes: a store's width wins over any load code.
  function automatic int model_size(input logic [1:0] mw, input logic [2:0] lc);
    if (mw == 2'b11) return 1;
    if (mw == 2'b10) return 2;
    if (mw == 2'b01) return 4;
    case (lc)
      3'b100, 3'b110:         return 1;
      3'b010, 3'b011, 3'b101: return 2;
      default:                return 4;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input int sz, input logic [31:0] a);
    int m;
    m = ((1 << sz) - 1) << int'(a[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] w);
    if (sz == 1) return {24'h0, w[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'h0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] lc,
                                             input logic [31:0] a);
    logic [31:0] v, h, b;
    v = word >> (8 * int'(a[1:0]));
    h = v & 32'h0000_FFFF;
    b = v & 32'h0000_00FF;
    case (lc)
      3'b011:  return h - ((h >= 32'd32768) ? 32'd65536 : 32'd0);
      3'b101:  return h;
      3'b100:  return b - ((b >= 32'd128) ? 32'd256 : 32'd0);
      3'b110:  return b;
      3'b010:  return h * 32'd65536;
      default: return word;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_req = 1'b0; exp_lv = 1'b0; exp_mis = 1'b0; exp_bus = 1'b0;
  endtask

  // ready_at: BUSY cycle (1-based) in which mem_ready is asserted; 0 = never.
  task automatic do_access(input logic rd, input logic [1:0] mw, input logic [2:0] lc,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] word, input int ready_at);
    logic wr, ld, mis, done;
    int sz;
    wr  = (mw != 2'b00);
    ld  = rd && !wr;
    sz  = model_size(mw, lc);
    mis = (int'(a[1:0]) % sz) != 0;
    MemRead = rd; MemWrite = mw; load_code = lc; addr = a; wdata = wd; mem_ready = 1'b0;
    set_idle_exp();
    exp_stall = 1'b1;
    step();
    if (mis) begin
      exp_stall = 1'b0;
      exp_mis   = 1'b1;
      step();
    end else begin
      exp_addr  = {a[31:2], 2'b00};
      exp_we    = wr;
      exp_mask  = model_mask(sz, a);
      exp_wdata = model_wdata(sz, wd);
      done = 1'b0;
      for (int k = 1; k <= TMO && !done; k++) begin
        exp_req   = 1'b1;
        exp_stall = 1'b1;
        done      = (k == ready_at);
        mem_ready = done;
        mem_rdata = done ? word : 32'h5A5A_5A5A;
        step();
      end
      mem_ready = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      exp_req   = 1'b0;
      exp_stall = 1'b0;
      if (done) begin
        exp_lv = ld;
        exp_ld = model_load(word, lc, a);
      end else begin
        exp_bus = 1'b1;
      end
      step();
    end
    MemRead = 1'b0; MemWrite = 2'b00;
    set_idle_exp();
    step();
  endtask

  int s0, r0, l0, m0, b0;

  task automatic snap();
    s0 = stall_total; r0 = req_total; l0 = lv_total; m0 = mis_total; b0 = bus_total;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 2'b00; load_code = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    set_idle_exp();
    exp_we = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0; exp_mask = 4'h0; exp_ld = 32'h0;

    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          if (stall)          stall_total++;
          if (mem_req)        req_total++;
          if (load_valid)     lv_total++;
          if (misaligned_err) mis_total++;
          if (bus_err)        bus_total++;
          check("stall", 32'(stall), 32'(exp_stall));
          check("mem_req", 32'(mem_req), 32'(exp_req));
          check("load_valid", 32'(load_valid), 32'(exp_lv));
          check("misaligned_err", 32'(misaligned_err), 32'(exp_mis));
          check("bus_err", 32'(bus_err), 32'(exp_bus));
          if (exp_req) begin
            check("mem_addr", mem_addr, exp_addr);
            check("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) begin
              check("mem_wmask", 32'(mem_wmask), 32'(exp_mask));
              check("mem_wdata", mem_wdata, exp_wdata);
            end
          end
          if (exp_lv) check("load_data", load_data, exp_ld);
        end
      end
    join_none

    repeat (3) step();
    reset = 1'b0;
    chk_en = 1'b1;
    step();
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_load_data", load_data, 32'h0);

    // lw, ready in the third request cycle
    snap();
    do_access(1'b1, 2'b00, 3'b001, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    check("lw_stall_cycles", 32'(stall_total - s0), 32'd4);
    check("lw_mem_addr", mem_addr, 32'h100);
    check("lw_load_data", load_data, 32'hDEAD_BEEF);
    check("lw_pulses", 32'(lv_total - l0), 32'd1);

    // sb, immediate ready
    snap();
    do_access(1'b0, 2'b11, 3'b000, 32'h203, 32'h0000_00A5, 32'h0, 1);
    check("sb_mem_addr", mem_addr, 32'h200);
    check("sb_mem_wmask", 32'(mem_wmask), 32'(4'b1000));
    check("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    check("sb_stall_cycles", 32'(stall_total - s0), 32'd2);
    check("sb_no_load_valid", 32'(lv_total - l0), 32'd0);

    // sh upper half
    do_access(1'b0, 2'b10, 3'b000, 32'h202, 32'h1234_BEEF, 32'h0, 2);
    check("sh_mem_wmask", 32'(mem_wmask), 32'(4'b1100));
    check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);

    do_access(1'b1, 2'b00, 3'b011, 32'h12, 32'h0, 32'h8001_7FFF, 1);
    check("lh_result", load_data, 32'hFFFF_8001);
    do_access(1'b1, 2'b00, 3'b101, 32'h12, 32'h0, 32'h8001_7FFF, 2);
    check("lhu_result", load_data, 32'h0000_8001);
    do_access(1'b1, 2'b00, 3'b010, 32'h12, 32'h0, 32'h8001_7FFF, 1);
    check("lth_result", load_data, 32'h8001_0000);
    do_access(1'b1, 2'b00, 3'b110, 32'h13, 32'h0, 32'h8001_7FFF, 1);
    check("lbu_result", load_data, 32'h0000_0080);
    do_access(1'b1, 2'b00, 3'b000, 32'h20, 32'h0, 32'h0BAD_F00D, 1);
    check("raw_result", load_data, 32'h0BAD_F00D);
    do_access(1'b1, 2'b00, 3'b100, 32'h11, 32'h0, 32'h8001_7FFF, 1);
    check("lb_result", load_data, 32'h0000_007F);

    // read and write together: the store wins, no load pulse
    snap();
    do_access(1'b1, 2'b01, 3'b001, 32'h50, 32'hCAFE_0001, 32'h1111_1111, 1);
    check("rw_no_load_valid", 32'(lv_total - l0), 32'd0);
    check("rw_load_data_held", load_data, 32'h0000_007F);

    // misaligned stores
    snap();
    do_access(1'b0, 2'b01, 3'b000, 32'h106, 32'h0, 32'h0, 0);
    check("sw_mis_pulses", 32'(mis_total - m0), 32'd1);
    check("sw_mis_no_req", 32'(req_total - r0), 32'd0);
    check("sw_mis_stall", 32'(stall_total - s0), 32'd1);
    snap();
    do_access(1'b0, 2'b10, 3'b000, 32'h107, 32'h0, 32'h0, 0);
    check("sh_mis_pulses", 32'(mis_total - m0), 32'd1);
    check("sh_mis_no_req", 32'(req_total - r0), 32'd0);

    // timeout
    snap();
    do_access(1'b1, 2'b00, 3'b001, 32'h40, 32'h0, 32'h0, 0);
    check("tmo_req_cycles", 32'(req_total - r0), 32'd4);
    check("tmo_bus_pulses", 32'(bus_total - b0), 32'd1);
    check("tmo_no_load_valid", 32'(lv_total - l0), 32'd0);

    // reset in the second BUSY cycle, then a late ready
    snap();
    MemRead = 1'b1; MemWrite = 2'b00; load_code = 3'b001; addr = 32'h300;
    set_idle_exp(); exp_stall = 1'b1;
    step();
    exp_req = 1'b1; exp_addr = 32'h300; exp_we = 1'b0;
    step();
    reset = 1'b1; MemRead = 1'b0;
    step();
    reset = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    set_idle_exp();
    step();
    check("rstmid_mem_addr", mem_addr, 32'h0);
    check("rstmid_load_data", load_data, 32'h0);
    check("rstmid_mem_wmask", 32'(mem_wmask), 32'h0);
    mem_ready = 1'b0;
    step();
    check("rstmid_no_load_valid", 32'(lv_total - l0), 32'd0);
    check("rstmid_req_cycles", 32'(req_total - r0), 32'd2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
